// File: rtl/dtree_node_loader.sv
// Byte-stream loader for the decision-tree classifier node memory: packs bytes MSB-first
// into node words and writes them sequentially. Optional trailer checksum: DTREE_LOADER_CHECKSUM_EN.
module dtree_node_loader #(
    parameter int FEATURES      = 3,
    parameter int COEFF_WIDTH   = 2,
    parameter int BIAS_WIDTH    = 10,
    parameter int MAX_CLUSTERS  = 5,
    parameter int CHANNEL_COUNT = 1,
    localparam int NODE_SIZE    = 2 + FEATURES + (FEATURES - 1) * COEFF_WIDTH + BIAS_WIDTH + 1,
    localparam int NODE_BYTES   = (NODE_SIZE + 7) / 8,
    localparam int TOTAL_NODES  = MAX_CLUSTERS * CHANNEL_COUNT,
    localparam int ADDR_W       = $clog2(TOTAL_NODES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic [7:0]           byte_data,
    output logic                 wr_node,
    output logic [ADDR_W-1:0]    node_addr,
    output logic [NODE_SIZE-1:0] node_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int SHIFT_W = NODE_BYTES * 8;
    localparam int BCNT_W  = $clog2(NODE_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
`ifdef DTREE_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [BCNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]    node_cnt_q, node_cnt_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d, shift_next;
    logic [ADDR_W-1:0]    node_addr_q, node_addr_d;
    logic [NODE_SIZE-1:0] node_data_q, node_data_d;
`ifdef DTREE_LOADER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    // The top byte falls off the end; only the low NODE_SIZE bits ever reach node_data.
    assign shift_next = SHIFT_W'({shift_q, byte_data});

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        node_cnt_d  = node_cnt_q;
        shift_d     = shift_q;
        node_addr_d = node_addr_q;
        node_data_d = node_data_q;
`ifdef DTREE_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                byte_cnt_d = '0;
                node_cnt_d = '0;
                shift_d    = '0;
`ifdef DTREE_LOADER_CHECKSUM_EN
                csum_d     = '0;
`endif
                if (start) state_d = RECV;
            end
            RECV: begin
                if (byte_valid) begin
                    shift_d = shift_next;
`ifdef DTREE_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_data;
`endif
                    // Address/data are registered here so they are valid throughout WRITE.
                    if (byte_cnt_q == BCNT_W'(NODE_BYTES - 1)) begin
                        byte_cnt_d  = '0;
                        node_addr_d = node_cnt_q;
                        node_data_d = NODE_SIZE'(shift_next);
                        state_d     = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    end
                end
            end
            WRITE: begin
                if (node_cnt_q == ADDR_W'(TOTAL_NODES - 1)) begin
`ifdef DTREE_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    node_cnt_d = node_cnt_q + ADDR_W'(1);
                    state_d    = RECV;
                end
            end
`ifdef DTREE_LOADER_CHECKSUM_EN
            CHECK: begin
                if (byte_valid) state_d = (byte_data == csum_q) ? DONE : ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            node_cnt_q  <= '0;
            shift_q     <= '0;
            node_addr_q <= '0;
            node_data_q <= '0;
`ifdef DTREE_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            node_cnt_q  <= node_cnt_d;
            shift_q     <= shift_d;
            node_addr_q <= node_addr_d;
            node_data_q <= node_data_d;
`ifdef DTREE_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign wr_node   = (state_q == WRITE);
    assign node_addr = node_addr_q;
    assign node_data = node_data_q;
    assign done      = (state_q == DONE);
`ifdef DTREE_LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == RECV) || (state_q == CHECK);
    assign busy       = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
    assign error      = (state_q == ERROR);
`else
    assign byte_ready = (state_q == RECV);
    assign busy       = (state_q == RECV) || (state_q == WRITE);
    assign error      = 1'b0;
`endif

endmodule

// File: doc/dtree_node_loader.md
# dtree_node_loader

Configuration-side writer for the decision-tree classifier's node memory. Accepts a byte stream over a valid/ready handshake, packs bytes MSB-first into node words, and issues one `wr_node` write per node with a sequential address. It writes all `MAX_CLUSTERS*CHANNEL_COUNT` nodes, then reports completion. It sits between the host and the classifier's `wr_node`/`node_addr`/`node_data_in` port. The classifier consumes that node sequence in address order until its node memory is full.

## Interface
- `FEATURES`, 3, features per sample
- `COEFF_WIDTH`, 2, coefficient width
- `BIAS_WIDTH`, 10, bias width
- `MAX_CLUSTERS`, 5, nodes per channel
- `CHANNEL_COUNT`, 1, channels
- Derived values:
  - NODE_SIZE = 2 + FEATURES + (FEATURES-1)*COEFF_WIDTH + BIAS_WIDTH + 1 (20 at defaults)
  - NODE_BYTES = (NODE_SIZE+7)/8 (3 at defaults)
  - TOTAL_NODES = MAX_CLUSTERS*CHANNEL_COUNT; must be ≥ 2
- Ports:
  - `clk`  in  1  clock
  - `reset`  in  1  reset, synchronous, active-high; clock clk
  - `start`  in  1  begin a load; sampled only in IDLE, DONE or ERROR
  - `byte_valid`  in  1  byte_data valid
  - `byte_ready`  out  1  loader accepts byte this cycle
  - `byte_data`  in  8  stream byte
  - `wr_node`  out  1  one-cycle node write strobe
  - `node_addr`  out  $clog2(TOTAL_NODES)  write address
  - `node_data`  out  NODE_SIZE  node word
  - `busy`  out  1  load in progress
  - `done`  out  1  all nodes written (sticky)
  - `error`  out  1  checksum mismatch (sticky)

## Operation
- Reset value of every output is 0.
- States: IDLE, RECV, WRITE, CHECK (only with macro), DONE, ERROR.
- IDLE:
  - `start`=1 → RECV.
  - Clears the byte counter, the node counter and the shift register.
  - Clears `done` and `error`.
- RECV:
  - `byte_ready`=1 and `busy`=1.
  - A byte is accepted when `byte_valid` and `byte_ready` are both high.
  - Each accepted byte shifts into a NODE_BYTES*8 register, MSB-first (first byte is most significant).
  - On the NODE_BYTES-th accepted byte → WRITE.
- WRITE (exactly one cycle):
  - `wr_node`=1 and `byte_ready`=0.
  - `node_data` = low NODE_SIZE bits of the shift register. The upper pad bits are discarded regardless of value.
  - `node_addr` = node counter.
  - Next state:
    - Node counter = TOTAL_NODES-1 → CHECK (macro) or DONE.
    - Otherwise, node counter increments and the state returns to RECV.
- `node_addr` and `node_data` hold their last written values outside WRITE.
- DONE:
  - `done`=1 and `busy`=0.
  - `start` → RECV with counters cleared and `done` cleared.
- ERROR:
  - `error`=1 and `busy`=0.
  - `start` → RECV with counters cleared and `error` cleared.
- `start` in RECV, WRITE or CHECK is ignored.
- `byte_valid` outside RECV/CHECK is ignored; no byte is consumed.
- Reset mid-load: the next cycle is IDLE with all outputs 0 and the node counter 0. Partially assembled bytes are lost.
- The loader does not reset the classifier. The system resets the classifier before any reload, because the classifier accepts writes only until it is full.

## Timing
- `wr_node` rises the cycle after the last byte of a node is accepted.
- Minimum cost per node is NODE_BYTES+1 cycles. A full load takes at least TOTAL_NODES*(NODE_BYTES+1) cycles after `start`.
- `done` rises the cycle after the final WRITE (without macro), or the cycle after the checksum byte is accepted (with macro).
- `byte_ready` is a registered state decode and does not depend combinationally on `byte_valid`.

## Configuration
- Macro: `DTREE_LOADER_CHECKSUM_EN`.
- Defined:
  - After the final WRITE, the loader enters CHECK with `byte_ready`=1.
  - It accepts one trailer byte and compares it with the XOR of every node byte accepted in this load, pad bits included.
  - Equal → DONE. Unequal → ERROR.
  - Node writes have already occurred by this point; `error` tells the system to reset and reload.
- Undefined: there is no CHECK state, no trailer byte is consumed, and `error` is tied to 0.

## Test plan
- Single node, defaults:
  - `start`, then bytes 0x0A, 0xBC, 0xDE → one `wr_node` pulse with `node_addr`=0, `node_data`=0xABCDE.
  - `byte_ready`=0 during that cycle.
- Pad discard: bytes 0xFA, 0xBC, 0xDE → `node_data`=0xABCDE.
- Full load of 15 bytes at full rate:
  - `wr_node` pulses for addresses 0,1,2,3,4 at cycles 4, 8, 12, 16, 20 after `start`.
  - `done`=1 after the last pulse (without macro); `busy` falls at the same time.
- Backpressure: `byte_valid` toggles 1/0 → identical write data and addresses, with stretched spacing; no byte is lost or duplicated.
- Reset after 7 accepted bytes:
  - All outputs are 0 the next cycle.
  - `start` plus 3 bytes → write at `node_addr`=0.
  - `start` pulses issued while `busy` have no effect.
- With `DTREE_LOADER_CHECKSUM_EN`:
  - 15 bytes followed by their correct XOR → `done`=1, `error`=0.
  - Same 15 bytes with the trailer XOR 0x01 → `error`=1, `done`=0.
  - A subsequent `start` clears `error`.
